qeciphy_clk_mmcm_ctrl: RTL and testbench

//  Reset/lock sequencer for the PHY clocking MMCM (clk_out, clk_out_2x). Holds the MMCM in reset

---
 rtl/qeciphy_pkg.sv | 34 +++
 rtl/qeciphy_sync_2ff.sv | 32 +++
 rtl/qeciphy_clk_mmcm_ctrl.sv | 149 ++++++++++++++
 tb/tb_qeciphy_clk_mmcm_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qeciphy_pkg.sv
`default_nettype none
// ============================================================================
// Module : qeciphy_pkg
// Brief  : Shared types and default constants for the QECIPHY MMCM controller.
// Rev    : 1.0 - initial release
// ============================================================================
package qeciphy_pkg;

    typedef enum logic [2:0] {
        HOLD   = 3'd0,
        WAIT   = 3'd1,
        SETTLE = 3'd2,
        READY  = 3'd3,
        FAULT  = 3'd4
    } mmcm_ctrl_state_t;

    localparam int DEF_RESET_CYCLES  = 64;
    localparam int DEF_DEBOUNCE      = 8;
    localparam int DEF_SETTLE_CYCLES = 1024;
    localparam int DEF_WAIT_TIMEOUT  = 4096;
    localparam int DEF_MAX_RETRIES   = 4;

    function automatic int max5(input int a, input int b, input int c, input int d, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/qeciphy_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module : qeciphy_sync_2ff
// Brief  : Two-flop single-bit synchroniser with configurable reset value.
// Rev    : 1.0 - initial release
// ============================================================================
module qeciphy_sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    (* async_reg = "true" *) logic r_meta;
    (* async_reg = "true" *) logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/qeciphy_clk_mmcm_ctrl.sv
`default_nettype none
// ============================================================================
// Module : qeciphy_clk_mmcm_ctrl
// Brief  : Reset/lock sequencer for the PHY clocking MMCM. Optional wait
//          timeout and retry limit enabled by QECIPHY_MMCM_CTRL_TIMEOUT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
module qeciphy_clk_mmcm_ctrl
    import qeciphy_pkg::*;
#(
    parameter int RESET_CYCLES  = DEF_RESET_CYCLES,
    parameter int DEBOUNCE      = DEF_DEBOUNCE,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int WAIT_TIMEOUT  = DEF_WAIT_TIMEOUT,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mmcm_clk_stopped_i,
    input  logic       restart_req_i,
    output logic       mmcm_reset_o,
    output logic       clk_ready_o,
    output logic       fault_o,
    output logic [3:0] restart_count_o,
    output logic [2:0] state_o
);

    localparam int CW = $clog2(max5(RESET_CYCLES, DEBOUNCE, SETTLE_CYCLES,
                                    WAIT_TIMEOUT, MAX_RETRIES) + 1);
    localparam logic [CW-1:0] C_HOLD_LAST   = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] C_DEB_LAST    = CW'(DEBOUNCE - 1);
    localparam logic [CW-1:0] C_SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

    logic             w_stopped;
    logic             w_fail;
    mmcm_ctrl_state_t w_next;
    mmcm_ctrl_state_t r_state;
    logic [CW-1:0]    r_cnt;
    logic [3:0]       r_count;
    logic             r_mmcm_reset;
    logic             r_clk_ready;

`ifdef QECIPHY_MMCM_CTRL_TIMEOUT_EN
    localparam int RW = $clog2(MAX_RETRIES + 1);
    localparam logic [CW-1:0] C_WAIT_LAST  = CW'(WAIT_TIMEOUT - 1);
    localparam logic [RW-1:0] C_RETRY_LAST = RW'(MAX_RETRIES - 1);
    logic [CW-1:0] r_wcnt;
    logic [RW-1:0] r_retry;
    logic          r_fault;
`endif

    qeciphy_sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync_stopped (
        .clk (clk),
        .rst (rst),
        .i_d (mmcm_clk_stopped_i),
        .o_q (w_stopped)
    );

    always_comb begin
        w_next = r_state;
        w_fail = 1'b0;
        case (r_state)
            HOLD: begin
                if (r_cnt == C_HOLD_LAST) w_next = WAIT;
            end
            WAIT: begin
                if (restart_req_i) w_next = HOLD;
                else if (!w_stopped && r_cnt == C_DEB_LAST) w_next = SETTLE;
`ifdef QECIPHY_MMCM_CTRL_TIMEOUT_EN
                else if (r_wcnt == C_WAIT_LAST) w_fail = 1'b1;
`endif
            end
            SETTLE: begin
                if (restart_req_i) w_next = HOLD;
                else if (w_stopped) w_fail = 1'b1;
                else if (r_cnt == C_SETTLE_LAST) w_next = READY;
            end
            READY: begin
                if (w_stopped || restart_req_i) w_next = HOLD;
            end
            FAULT: begin
                if (restart_req_i) w_next = HOLD;
            end
            default: w_next = HOLD;
        endcase
        // A failed attempt either retries or, once the budget is spent, parks in FAULT
        if (w_fail) begin
`ifdef QECIPHY_MMCM_CTRL_TIMEOUT_EN
            w_next = (r_retry >= C_RETRY_LAST) ? FAULT : HOLD;
`else
            w_next = HOLD;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= HOLD;
            r_cnt        <= '0;
            r_count      <= 4'd0;
            r_mmcm_reset <= 1'b1;
            r_clk_ready  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_cnt <= '0;
            else if (r_state == WAIT && w_stopped)
                r_cnt <= '0;
            else if (r_state != READY && r_state != FAULT)
                r_cnt <= r_cnt + 1'b1;
            if (r_state == READY && w_stopped && r_count != 4'hF)
                r_count <= r_count + 4'd1;
            r_mmcm_reset <= (w_next == HOLD) || (w_next == FAULT);
            r_clk_ready  <= (w_next == READY);
        end
    end

`ifdef QECIPHY_MMCM_CTRL_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wcnt  <= '0;
            r_retry <= '0;
            r_fault <= 1'b0;
        end else begin
            if (w_next != r_state)
                r_wcnt <= '0;
            else if (r_state == WAIT)
                r_wcnt <= r_wcnt + 1'b1;
            if (w_fail)
                r_retry <= r_retry + 1'b1;
            else if (w_next == READY || (r_state == FAULT && w_next == HOLD))
                r_retry <= '0;
            r_fault <= (w_next == FAULT);
        end
    end
    assign fault_o = r_fault;
`else
    assign fault_o = 1'b0;
`endif

    assign mmcm_reset_o    = r_mmcm_reset;
    assign clk_ready_o     = r_clk_ready;
    assign restart_count_o = r_count;
    assign state_o         = r_state;

endmodule
`default_nettype wire

// File: tb/tb_qeciphy_clk_mmcm_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_qeciphy_clk_mmcm_ctrl
// Brief  : Directed bench with a behavioural reference model for the MMCM
//          sequencer; follows QECIPHY_MMCM_CTRL_TIMEOUT_EN like the design.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_qeciphy_clk_mmcm_ctrl;

    localparam int RESET_CYCLES  = 64;
    localparam int DEBOUNCE      = 8;
    localparam int SETTLE_CYCLES = 1024;
    localparam int WAIT_TIMEOUT  = 4096;
    localparam int MAX_RETRIES   = 4;
`ifdef QECIPHY_MMCM_CTRL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam int P_HOLD = 0, P_WAIT = 1, P_SETTLE = 2, P_READY = 3, P_FAULT = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       stop_in;
    logic       req;
    logic       mreset;
    logic       ready;
    logic       fault;
    logic [3:0] rcount;
    logic [2:0] state;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    qeciphy_clk_mmcm_ctrl #(
        .RESET_CYCLES  (RESET_CYCLES),
        .DEBOUNCE      (DEBOUNCE),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .WAIT_TIMEOUT  (WAIT_TIMEOUT),
        .MAX_RETRIES   (MAX_RETRIES)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .mmcm_clk_stopped_i (stop_in),
        .restart_req_i      (req),
        .mmcm_reset_o       (mreset),
        .clk_ready_o        (ready),
        .fault_o            (fault),
        .restart_count_o    (rcount),
        .state_o            (state)
    );

    // Reference model: phase plus elapsed-time bookkeeping, stopped seen two edges late
    typedef struct {
        int       ph;
        int       elapsed;
        int       clean;
        int       waited;
        int       fails;
        int       restarts;
        bit [1:0] hist;
    } model_t;

    model_t m;

    function automatic model_t enter(input model_t x, input int ph);
        model_t y;
        y = x;
        y.ph = ph;
        y.elapsed = 0;
        y.clean = 0;
        y.waited = 0;
        return y;
    endfunction

    function automatic model_t model_reset();
        model_t y;
        y.ph = P_HOLD; y.elapsed = 0; y.clean = 0; y.waited = 0;
        y.fails = 0; y.restarts = 0; y.hist = 2'b11;
        return y;
    endfunction

    function automatic model_t model_step(input model_t x, input bit din, input bit rq);
        model_t n;
        bit s;
        bit failed;
        n = x;
        s = x.hist[1];
        failed = 1'b0;
        n.hist = {x.hist[0], din};
        case (x.ph)
            P_HOLD: begin
                n.elapsed = x.elapsed + 1;
                if (n.elapsed == RESET_CYCLES) n = enter(n, P_WAIT);
            end
            P_WAIT: begin
                if (rq) n = enter(n, P_HOLD);
                else begin
                    n.clean  = s ? 0 : x.clean + 1;
                    n.waited = x.waited + 1;
                    if (n.clean == DEBOUNCE) n = enter(n, P_SETTLE);
                    else if (TO_EN && n.waited == WAIT_TIMEOUT) failed = 1'b1;
                end
            end
            P_SETTLE: begin
                if (rq) n = enter(n, P_HOLD);
                else if (s) failed = 1'b1;
                else begin
                    n.elapsed = x.elapsed + 1;
                    if (n.elapsed == SETTLE_CYCLES) begin
                        n = enter(n, P_READY);
                        n.fails = 0;
                    end
                end
            end
            P_READY: begin
                if (s && x.restarts < 15) n.restarts = x.restarts + 1;
                if (s || rq) n = enter(n, P_HOLD);
            end
            default: begin
                if (rq) begin
                    n = enter(n, P_HOLD);
                    n.fails = 0;
                end
            end
        endcase
        if (failed) begin
            n.fails = x.fails + 1;
            n = enter(n, (TO_EN && n.fails >= MAX_RETRIES) ? P_FAULT : P_HOLD);
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= model_reset();
        else     m <= model_step(m, stop_in, req);
    end

    always @(negedge clk) begin
        #2;
        n_vec++;
        if (state  !== 3'(m.ph) ||
            mreset !== (m.ph == P_HOLD || m.ph == P_FAULT) ||
            ready  !== (m.ph == P_READY) ||
            fault  !== (m.ph == P_FAULT) ||
            rcount !== 4'(m.restarts)) begin
            n_err++;
            $display("FAIL model_cmp t=%0t got st=%0d rst=%b rdy=%b flt=%b cnt=%0d exp st=%0d rst=%b rdy=%b flt=%b cnt=%0d",
                     $time, state, mreset, ready, fault, rcount, m.ph,
                     (m.ph == P_HOLD || m.ph == P_FAULT), (m.ph == P_READY),
                     (m.ph == P_FAULT), m.restarts);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_state(input int s, input int budget);
        int k;
        k = 0;
        while (int'(state) != s && k < budget) begin
            tick(1);
            k++;
        end
        check("wait_state", int'(state), s);
    endtask

    initial begin
        rst = 1'b1; stop_in = 1'b0; req = 1'b0;
        tick(3);
        check("rst_state", state, 0);
        check("rst_mreset", mreset, 1);
        check("rst_ready", ready, 0);
        check("rst_fault", fault, 0);
        check("rst_count", rcount, 0);
        rst = 1'b0;

        // bring-up: 64 cycles in reset, ready after 64 + 8 + 1024 edges
        tick(63);
        check("hold_hi", mreset, 1);
        tick(1);
        check("hold_lo", mreset, 0);
        check("enter_wait", state, 1);
        tick(1031);
        check("ready_early", ready, 0);
        tick(1);
        check("ready_rise", ready, 1);
        check("ready_state", state, 3);

        // stop coincident with restart request: one HOLD entry, count +1
        stop_in = 1'b1;
        tick(2);
        check("ready_hold_sync", ready, 1);
        req = 1'b1;
        tick(1);
        req = 1'b0;
        check("coinc_state", state, 0);
        check("coinc_count", rcount, 1);
        check("coinc_ready", ready, 0);
        tick(17);
        stop_in = 1'b0;
        wait_state(3, 2000);

        // repeated clock stops, count saturates
        for (int i = 0; i < 16; i++) begin
            stop_in = 1'b1;
            tick(20);
            stop_in = 1'b0;
            if (i == 0) check("stop_count2", rcount, 2);
            wait_state(3, 2000);
        end
        check("count_sat", rcount, 15);

        // software restart, then a chattering clock in WAIT
        req = 1'b1;
        tick(1);
        req = 1'b0;
        check("sw_restart_state", state, 0);
        check("sw_restart_count", rcount, 15);
        wait_state(1, 200);
        for (int i = 0; i < 50; i++) begin
            stop_in = ~stop_in;
            tick(4);
        end
        check("chatter_wait", state, 1);

        // clock loss 500 cycles into SETTLE
        stop_in = 1'b0;
        wait_state(2, 100);
        tick(500);
        stop_in = 1'b1;
        tick(2);
        check("settle_before", state, 2);
        tick(1);
        check("settle_drop", state, 0);
        stop_in = 1'b0;
        wait_state(2, 200);
        tick(10);

        // asynchronous reset mid-SETTLE
        rst = 1'b1;
        #3;
        check("arst_state", state, 0);
        check("arst_mreset", mreset, 1);
        check("arst_count", rcount, 0);
        stop_in = 1'b1;
        tick(2);
        rst = 1'b0;

`ifdef QECIPHY_MMCM_CTRL_TIMEOUT_EN
        // four attempts of 64 + 4096 cycles, then FAULT
        tick(4 * (RESET_CYCLES + WAIT_TIMEOUT) - 1);
        check("fault_early", fault, 0);
        tick(1);
        check("fault_set", fault, 1);
        check("fault_mreset", mreset, 1);
        check("fault_state", state, 4);
        tick(5);
        req = 1'b1;
        tick(1);
        req = 1'b0;
        check("fault_clear", fault, 0);
        check("fault_exit", state, 0);
        stop_in = 1'b0;
        wait_state(3, 2000);
`else
        tick(20000);
        check("stuck_state", state, 1);
        check("stuck_fault", fault, 0);
        check("stuck_mreset", mreset, 0);
`endif

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
